// File: rtl/tbird_pkg.sv
// Shared constants for the turn-signal block.
//   DEBOUNCE_CNT_DEFAULT / TICK_DIV_DEFAULT : default parameter values
//   REQ_*                                   : bit positions of the request vector
//   LIGHTS_*                                : lamp patterns {LC,LB,LA,RA,RB,RC} used by the FSM
package tbird_pkg;
  localparam int DEBOUNCE_CNT_DEFAULT = 4;
  localparam int TICK_DIV_DEFAULT     = 8;

  localparam int NUM_REQ   = 3;
  localparam int REQ_LEFT  = 0;
  localparam int REQ_RIGHT = 1;
  localparam int REQ_HAZ   = 2;

  localparam logic [5:0] LIGHTS_OFF = 6'b000_000;
  localparam logic [5:0] LIGHTS_L1  = 6'b001_000;
  localparam logic [5:0] LIGHTS_L2  = 6'b011_000;
  localparam logic [5:0] LIGHTS_L3  = 6'b111_000;
  localparam logic [5:0] LIGHTS_R1  = 6'b000_100;
  localparam logic [5:0] LIGHTS_R2  = 6'b000_110;
  localparam logic [5:0] LIGHTS_R3  = 6'b000_111;
  localparam logic [5:0] LIGHTS_ALL = 6'b111_111;
endpackage

// File: rtl/tbird_debounce.sv
// Single-input conditioner: 2-flop synchronizer, mismatch counter, accepted level.
//   clk, reset_n : clock, async active-low reset
//   raw          : asynchronous switch input
//   level        : accepted (debounced) level, registered
//   level_nxt    : value level takes at the next edge; lets the parent see a
//                  rise on the same edge it is registered
module tbird_debounce
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic level_nxt
);
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  assign differ    = sync[1] ^ level;
  // Stable for DEBOUNCE_CNT consecutive cycles: this edge is the last one.
  assign accept    = differ && (cnt == LAST);
  assign level_nxt = accept ? sync[1] : level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      level <= level_nxt;
      if (!differ || accept) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/turn_input_conditioner.sv
// Conditions the three turn-signal switches and paces the downstream FSM.
//   clk, reset_n              : clock, async active-low reset (released synchronously upstream)
//   raw_left/raw_right/raw_haz: asynchronous switch inputs
//   LEFT/RIGHT/HAZ            : debounced request levels (LEFT and RIGHT may both be 1)
//   step_tick                 : one-cycle pulse every TICK_DIV cycles
// Build option TURN_HAZ_TOGGLE_EN: HAZ toggles on each debounced raw_haz press
// instead of following the debounced level.
module turn_input_conditioner
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT,
  parameter int TICK_DIV     = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_haz,
  output logic LEFT,
  output logic RIGHT,
  output logic HAZ,
  output logic step_tick
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

  logic [NUM_REQ-1:0] raw, lvl, lvl_nxt;
  logic               haz_nxt;
  logic               restart;
  logic [TW-1:0]      tick_cnt;

  assign raw[REQ_LEFT]  = raw_left;
  assign raw[REQ_RIGHT] = raw_right;
  assign raw[REQ_HAZ]   = raw_haz;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_db
    tbird_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (raw[i]),
      .level     (lvl[i]),
      .level_nxt (lvl_nxt[i])
    );
  end

  assign LEFT  = lvl[REQ_LEFT];
  assign RIGHT = lvl[REQ_RIGHT];

`ifdef TURN_HAZ_TOGGLE_EN
  logic haz_q;
  // Flip on the debounced press only; release leaves the latch alone.
  assign haz_nxt = haz_q ^ (lvl_nxt[REQ_HAZ] & ~lvl[REQ_HAZ]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) haz_q <= 1'b0;
    else          haz_q <= haz_nxt;
  end
  assign HAZ = haz_q;
`else
  assign haz_nxt = lvl_nxt[REQ_HAZ];
  assign HAZ     = lvl[REQ_HAZ];
`endif

  // Idle -> active on this edge: realign the divider so the FSM's first step
  // lands a full period after the request appears.
  assign restart = ~(LEFT | RIGHT | HAZ) &
                   (lvl_nxt[REQ_LEFT] | lvl_nxt[REQ_RIGHT] | haz_nxt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               tick_cnt <= '0;
    else if (restart)           tick_cnt <= '0;
    else if (tick_cnt == TLAST) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  assign step_tick = (tick_cnt == TLAST);
endmodule

// File: tb/tb_turn_input_conditioner.sv
module tb_turn_input_conditioner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_left = 1'b0, raw_right = 1'b0, raw_haz = 1'b0;
  logic LEFT, RIGHT, HAZ, step_tick;
  logic [3:0] obs;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string      name;
    logic [3:0] exp;   // {step_tick, HAZ, RIGHT, LEFT}
    logic [3:0] mask;
  } chk_t;
  chk_t sbq[$];

  typedef struct {
    string      name;
    logic [2:0] sel;   // {haz, right, left} inputs pulsed
    int         len;   // cycles held high
  } vec_t;
  vec_t tbl[5];

  turn_input_conditioner #(.DEBOUNCE_CNT(4), .TICK_DIV(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_left  (raw_left),
    .raw_right (raw_right),
    .raw_haz   (raw_haz),
    .LEFT      (LEFT),
    .RIGHT     (RIGHT),
    .HAZ       (HAZ),
    .step_tick (step_tick)
  );

  assign obs = {step_tick, HAZ, RIGHT, LEFT};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200us");
    $fatal(1);
  end

  function automatic void check(string nm, logic [3:0] act, logic [3:0] exp, logic [3:0] mask);
    nchk++;
    if ((act & mask) !== (exp & mask)) begin
      nerr++;
      $display("FAIL %s: got %b want %b (mask %b) at %0t", nm, act, exp, mask, $time);
    end
  endfunction

  // Expectation queued as the stimulus for the coming edge is committed,
  // popped and compared once the edge has produced its result.
  task automatic cyc(input string nm, input logic [3:0] exp, input logic [3:0] mask);
    chk_t c;
    sbq.push_back('{nm, exp, mask});
    @(posedge clk);
    @(negedge clk);
    c = sbq.pop_front();
    check(c.name, obs, c.exp, c.mask);
  endtask

  // raw_left already low: LEFT drops on edge 6 after the fall is sampled.
  task automatic left_fall(input string nm);
    for (int k = 1; k <= 8; k++) cyc(nm, {3'b000, k < 6}, 4'b0001);
  endtask

  initial begin
    tbl[0] = '{"right_3",  3'b010, 3};
    tbl[1] = '{"right_6",  3'b010, 6};
    tbl[2] = '{"left_2",   3'b001, 2};
    tbl[3] = '{"left_4",   3'b001, 4};
    tbl[4] = '{"both_5",   3'b011, 5};

    // Reset held with raw_left high and clock running: everything stays 0.
    raw_left = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) cyc("reset_hold", 4'b0000, 4'b1111);

    // Release with raw_left held: LEFT rises on edge 6, not before.
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) cyc("rel_left", {3'b000, k >= 6}, 4'b0111);

    // Asynchronous assertion clears outputs without a clock edge.
    #2 reset_n = 1'b0;
    #1 check("async_rst", obs, 4'b0000, 4'b1111);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) cyc("rel_left2", {3'b000, k >= 6}, 4'b0111);
    raw_left = 1'b0;
    left_fall("left_fall1");

    // Reset mid-debounce (count reaches 2 on edge 4): partial count dropped.
    raw_left = 1'b1;
    for (int k = 1; k <= 4; k++) cyc("mid_pre", 4'b0000, 4'b0001);
    reset_n = 1'b0;
    cyc("mid_rst", 4'b0000, 4'b1111);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) cyc("mid_fresh", {3'b000, k >= 6}, 4'b0001);
    raw_left = 1'b0;
    left_fall("left_fall2");

    // Pulse table: a held pulse of len>=4 shows on edges 6..len+5.
    for (int t = 0; t < 5; t++) begin
      for (int k = 1; k <= tbl[t].len + 10; k++) begin
        logic b;
        raw_left  = tbl[t].sel[0] && (k <= tbl[t].len);
        raw_right = tbl[t].sel[1] && (k <= tbl[t].len);
        b = (tbl[t].len >= 4) && (k >= 6) && (k <= tbl[t].len + 5);
        cyc(tbl[t].name, {1'b0, 1'b0, tbl[t].sel[1] & b, tbl[t].sel[0] & b}, 4'b0111);
      end
    end
    raw_left  = 1'b0;
    raw_right = 1'b0;

    // Free-running divider: find a tick (bounded), then period 8.
    begin
      bit found = 1'b0;
      for (int i = 0; i < 9 && !found; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (step_tick) found = 1'b1;
      end
      nchk++;
      if (!found) begin
        nerr++;
        $display("FAIL tick_search: no step_tick in 9 cycles, want one");
      end
    end
    for (int j = 1; j <= 16; j++) cyc("tick_free", {(j % 8) == 0, 3'b000}, 4'b1000);

    // LEFT rises on edge 6 (mid-period): ticks move to edges 13, 21, 29.
    raw_left = 1'b1;
    for (int k = 1; k <= 30; k++)
      cyc("tick_restart", {(k == 13) || (k == 21) || (k == 29), 2'b00, k >= 6}, 4'b1001);
    raw_left = 1'b0;
    left_fall("left_fall3");

    // Two separate 10-cycle raw_haz presses.
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 20; k++) begin
        logic h;
        raw_haz = (k <= 10);
`ifdef TURN_HAZ_TOGGLE_EN
        h = (p == 0) ? (k >= 6) : (k < 6);
`else
        h = (k >= 6) && (k <= 15);
`endif
        cyc(p == 0 ? "haz_press1" : "haz_press2", {1'b0, h, 2'b00}, 4'b0111);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/turn_input_conditioner.md
TURN_INPUT_CONDITIONER -- requirements
Module: turn_input_conditioner

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 4: consecutive stable cycles required to accept a new input level (range 2..65535).
- REQ-002 The block SHALL have parameter TICK_DIV, default 8: clock cycles per step_tick period (range 2..2^24).
- REQ-003 The block SHALL have port clk, input, 1: the single clock; all flops update on its rising edge.
- REQ-004 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
- REQ-005 The block SHALL have ports raw_left, raw_right and raw_haz, input, 1 each: asynchronous switch inputs.
- REQ-006 The block SHALL have ports LEFT, RIGHT and HAZ, output, 1 each: conditioned request levels for the downstream turn-signal FSM.
- REQ-007 The block SHALL have port step_tick, output, 1: one-cycle enable pulse pacing the downstream FSM.

Function
- REQ-008 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
- REQ-009 Per input, a counter SHALL increment on every cycle where the synchronized value differs from the accepted value, and clear on any cycle where they match.
- REQ-010 When the counter equals DEBOUNCE_CNT-1 and the values still differ, the accepted value SHALL take the synchronized value at that edge and the counter SHALL clear.
- REQ-011 A held raw change SHALL appear on the output at the (DEBOUNCE_CNT+2)th rising edge, counting the edge that first samples it as edge 1.
- REQ-012 Any pulse or glitch shorter than DEBOUNCE_CNT synchronized cycles SHALL produce no output change.
- REQ-013 LEFT and RIGHT SHALL equal their accepted values, with no mutual exclusion; both may be 1 simultaneously.
- REQ-014 The tick counter SHALL run 0..TICK_DIV-1 and wrap to 0.
- REQ-015 step_tick SHALL be 1 for exactly one cycle, while the count equals TICK_DIV-1.
- REQ-016 If, on a given edge, any of LEFT/RIGHT/HAZ rises while all three were 0, the tick counter SHALL load 0, so the first step_tick follows exactly TICK_DIV cycles later.
- REQ-017 This restart SHALL take priority over the wrap.
- REQ-018 The counter widths SHALL be $clog2 of the parameters; no counter SHALL overflow or saturate past its terminal value.

Reset
- REQ-019 While reset_n is 0, all synchronizer flops, accepted values, debounce counters and the tick counter SHALL be 0.
- REQ-020 While reset_n is 0, LEFT, RIGHT, HAZ and step_tick SHALL be 0, independent of clk.
- REQ-021 Reset asserted mid-debounce SHALL discard the partial count; after release, a held input SHALL need the full DEBOUNCE_CNT+2 edges again.
- REQ-022 Reset release SHALL be synchronized externally; the block SHALL NOT add a reset synchronizer.

Configuration
- REQ-023 Macro TURN_HAZ_TOGGLE_EN SHALL select the HAZ behaviour.
- REQ-024 With TURN_HAZ_TOGGLE_EN defined, HAZ SHALL be a latch that toggles on each 0->1 transition of the debounced raw_haz, and SHALL be unaffected by its release.
- REQ-025 Without TURN_HAZ_TOGGLE_EN, HAZ SHALL equal the debounced raw_haz level.
- REQ-026 In both cases, the HAZ rise SHALL count for REQ-016.

Structure
- REQ-027 Package tbird_pkg SHALL hold DEBOUNCE_CNT_DEFAULT, TICK_DIV_DEFAULT and the shared light-pattern constants used by the FSM.
- REQ-028 Sub-module tbird_debounce (synchronizer, counter and accepted value, parameterised by DEBOUNCE_CNT) SHALL be instantiated three times.
- REQ-029 The tick divider and the HAZ logic SHALL live in the top level.

Verification (DEBOUNCE_CNT=4, TICK_DIV=8)
- REQ-030 Bench SHALL cover: reset_n=0 with raw_left=1 toggling clk -> all outputs 0; release with raw_left held -> LEFT=1 after edge 6, never earlier.
- REQ-031 Bench SHALL cover: raw_right high for 3 cycles then low -> RIGHT stays 0 throughout; high for 6 cycles -> RIGHT=1 after edge 6, returns 0 six edges after the fall.
- REQ-032 Bench SHALL cover: all inputs idle, free run -> step_tick high once every 8 cycles; LEFT rises mid-period -> next step_tick exactly 8 cycles after the LEFT rise, period 8 thereafter.
- REQ-033 Bench SHALL cover: raw_left and raw_right asserted together -> LEFT and RIGHT rise on the same edge.
- REQ-034 Bench SHALL cover, with TURN_HAZ_TOGGLE_EN: two separate 10-cycle raw_haz presses -> HAZ 0->1 after press 1, holds through release, 1->0 after press 2. Without the macro: HAZ follows the press with a 6-edge lag on each transition.
- REQ-035 Bench SHALL cover: reset_n pulsed low at count 2 of a debounce -> LEFT stays 0, then requires 6 fresh edges after release.
